// File: rtl/sevenseg_demux.sv
// Receive side of a scanned 7-segment bus: samples segment/anode lines, rebuilds one
// debounced pattern per digit, and decodes each pattern to a hex nibble.
module sevenseg_demux #(
  parameter int N      = 2,
  parameter int STABLE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cathod,
  input  logic [6:0]          seg_in,
  input  logic [N-1:0]        an_in,
  output logic [N-1:0][6:0]   digit_values,
  output logic [N-1:0][3:0]   hex_value,
  output logic [N-1:0]        hex_valid,
  output logic                frame_done,
  output logic                sel_err
);

  localparam int              CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [6:0]      BLANK   = 7'h7F;

  // Stage 1: raw bus registers
  logic [6:0]   seg_q;
  logic [N-1:0] an_q;
  logic         cathod_q;

  // Stage 2: per-digit filter and frame tracking
  logic [N-1:0][6:0]    cand_q, cand_d;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0][6:0]    digit_q, digit_d;
  logic [N-1:0]         seen_q, seen_d, seen_hit;
  logic                 frame_done_q, frame_done_d;
  logic                 sel_err_q, sel_err_d;

  logic [6:0]   pat;
  logic [N-1:0] sel;
  logic         sel_one;
  logic         sel_multi;

  // Reset leaves cathod_q=1 with no anode set, which normalises to "no digit selected".
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q    <= BLANK;
      an_q     <= '0;
      cathod_q <= 1'b1;
    end else begin
      seg_q    <= seg_in;
      an_q     <= an_in;
      cathod_q <= cathod;
    end
  end

  always_comb begin
    pat       = cathod_q ? seg_q : ~seg_q;
    sel       = cathod_q ? an_q  : ~an_q;
    sel_one   = (sel != '0) && ((sel & (sel - N'(1))) == '0);
    sel_multi = (sel != '0) && !sel_one;
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    for (int i = 0; i < N; i++) begin
      if (sel_one && sel[i]) begin
        if (pat == cand_q[i]) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CNT_ONE;
        end else begin
          cand_d[i] = pat;
          cnt_d[i]  = CNT_ONE;
        end
        if (cnt_d[i] == CNT_MAX) digit_d[i] = pat;
      end
    end
  end

  // The completing sample is not carried into the next frame.
  always_comb begin
    seen_hit     = seen_q | sel;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    sel_err_d    = sel_multi;
    if (sel_one) begin
      if (&seen_hit) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cand_q       <= {N{BLANK}};
      cnt_q        <= '0;
      digit_q      <= {N{BLANK}};
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  // Returns {valid, nibble}; unknown glyphs decode to {0, 0}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    hex_value = '0;
    hex_valid = '0;
    for (int i = 0; i < N; i++) begin
      {hex_valid[i], hex_value[i]} = decode(digit_q[i]);
    end
  end

  assign digit_values = digit_q;
  assign frame_done   = frame_done_q;
  assign sel_err      = sel_err_q;

endmodule

// File: tb/tb_sevenseg_demux.sv
// Bench for sevenseg_demux: directed bus traffic, a per-digit behavioural model whose
// expectations are queued with the two-cycle latency, and literal spot checks.
module tb_sevenseg_demux;

  localparam int N      = 2;
  localparam int STABLE = 2;
  localparam int W      = N * 7 + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              cathod;
  logic [6:0]        seg_in;
  logic [N-1:0]      an_in;
  logic [N-1:0][6:0] digit_values;
  logic [N-1:0][3:0] hex_value;
  logic [N-1:0]      hex_valid;
  logic              frame_done;
  logic              sel_err;

  int checks  = 0;
  int errors  = 0;
  int fd_seen = 0;
  int se_seen = 0;

  always #5 clk = ~clk;

  sevenseg_demux #(.N(N), .STABLE(STABLE)) dut (
    .clk          (clk),
    .reset        (reset),
    .cathod       (cathod),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .digit_values (digit_values),
    .hex_value    (hex_value),
    .hex_valid    (hex_valid),
    .frame_done   (frame_done),
    .sel_err      (sel_err)
  );

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: candidate, run length, shown pattern and frame membership per digit
  logic [6:0] m_cand [N];
  logic [6:0] m_disp [N];
  int         m_cnt  [N];
  bit         m_seen [N];

  // Record per input cycle: {digit patterns, frame_done, sel_err}
  logic [W-1:0] exp_q[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cand[i] = 7'h7F;
      m_disp[i] = 7'h7F;
      m_cnt[i]  = 0;
      m_seen[i] = 1'b0;
    end
  endfunction

  function automatic logic [W-1:0] pack_rec(input logic fd, input logic se);
    logic [N-1:0][6:0] dv;
    for (int i = 0; i < N; i++) dv[i] = m_disp[i];
    return {dv, fd, se};
  endfunction

  function automatic logic [4:0] exp_hex(input logic [6:0] p);
    for (int g = 0; g < 16; g++) begin
      if (glyph[g] == p) return {1'b1, 4'(g)};
    end
    return 5'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: apply inputs, advance the model, then step one clock.
  task automatic drive(input logic rst, input logic c, input logic [N-1:0] an,
                       input logic [6:0] seg);
    logic [6:0]   pat;
    logic [N-1:0] sel;
    logic         fd;
    logic         se;
    int           idx;
    bit           all;
    reset  = rst;
    cathod = c;
    an_in  = an;
    seg_in = seg;
    fd     = 1'b0;
    se     = 1'b0;
    idx    = 0;
    if (!rst) begin
      // The sample still in flight when reset hits is lost as well.
      model_reset();
      if (exp_q.size() > 0) exp_q[exp_q.size() - 1] = pack_rec(1'b0, 1'b0);
    end else begin
      pat = c ? seg : ~seg;
      sel = c ? an : ~an;
      if ($countones(sel) > 1) begin
        se = 1'b1;
      end else if ($countones(sel) == 1) begin
        for (int i = 0; i < N; i++) if (sel[i]) idx = i;
        if (pat == m_cand[idx]) begin
          m_cnt[idx] = (m_cnt[idx] < STABLE) ? m_cnt[idx] + 1 : STABLE;
        end else begin
          m_cand[idx] = pat;
          m_cnt[idx]  = 1;
        end
        if (m_cnt[idx] == STABLE) m_disp[idx] = pat;
        m_seen[idx] = 1'b1;
        all = 1'b1;
        for (int i = 0; i < N; i++) if (!m_seen[i]) all = 1'b0;
        if (all) begin
          fd = 1'b1;
          for (int i = 0; i < N; i++) m_seen[i] = 1'b0;
        end
      end
    end
    exp_q.push_back(pack_rec(fd, se));
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic c, input int d, input logic [6:0] p);
    logic [N-1:0] oh;
    oh    = '0;
    oh[d] = 1'b1;
    drive(1'b1, c, c ? oh : ~oh, c ? p : ~p);
  endtask

  task automatic idle(input logic c);
    drive(1'b1, c, c ? '0 : '1, 7'h00);
  endtask

  task automatic do_reset(input logic c);
    drive(1'b0, c, c ? '0 : '1, 7'h00);
  endtask

  // Compare process: outputs after edge k+2 must match the record of input cycle k.
  initial begin
    logic [W-1:0]      rec;
    logic [N-1:0][6:0] dv;
    logic [N-1:0][3:0] ehv;
    logic [N-1:0]      evd;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_seen++;
      if (sel_err === 1'b1) se_seen++;
      if (exp_q.size() == 3) begin
        rec = exp_q.pop_front();
        dv  = rec[W-1:2];
        for (int i = 0; i < N; i++) {evd[i], ehv[i]} = exp_hex(dv[i]);
        check("digit_values", digit_values, dv);
        check("hex_value", hex_value, ehv);
        check("hex_valid", hex_valid, evd);
        check("frame_done", frame_done, rec[1]);
        check("sel_err", sel_err, rec[0]);
      end
    end
  end

  initial begin
    int fd_base;
    int se_base;
    model_reset();
    repeat (3) do_reset(1'b0);
    check("reset_digits", digit_values, 14'h3FFF);
    check("reset_hex_valid", hex_valid, 2'b00);
    check("reset_hex_value", hex_value, 8'h00);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_sel_err", sel_err, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // Active-high segments, active-low anodes
    fd_base = fd_seen;
    repeat (2) begin
      repeat (4) samp(1'b0, 0, 7'h79);
      repeat (4) samp(1'b0, 1, 7'h40);
    end
    idle(1'b0);
    idle(1'b0);
    check("t1_digit0", digit_values[0], 7'h79);
    check("t1_digit1", digit_values[1], 7'h40);
    check("t1_hex", hex_value, 8'h01);
    check("t1_valid", hex_valid, 2'b11);
    check("t1_frames", fd_seen - fd_base, 3);
    check("t1_model_digit0", m_disp[0], 7'h79);

    // Opposite polarity, then polarity flipping every sample with a coherent bus
    do_reset(1'b1);
    repeat (4) samp(1'b1, 0, 7'h79);
    repeat (4) samp(1'b1, 1, 7'h40);
    for (int k = 0; k < 6; k++) samp(k[0], k % 2 == 0 ? 0 : 1, k % 2 == 0 ? 7'h79 : 7'h40);
    idle(1'b1);
    idle(1'b1);
    check("t2_digits", digit_values, {7'h40, 7'h79});

    // Single-sample glitch is filtered, a two-sample change commits
    repeat (4) samp(1'b1, 0, 7'h24);
    samp(1'b1, 0, 7'h30);
    repeat (3) samp(1'b1, 0, 7'h24);
    idle(1'b1);
    idle(1'b1);
    check("t3_glitch", digit_values[0], 7'h24);
    samp(1'b1, 0, 7'h30);
    samp(1'b1, 0, 7'h30);
    check("t3_before_commit", digit_values[0], 7'h24);
    idle(1'b1);
    check("t3_commit", digit_values[0], 7'h30);

    // Multi-select is discarded and flagged; idle bus is not an error
    do_reset(1'b0);
    fd_base = fd_seen;
    se_base = se_seen;
    samp(1'b0, 0, 7'h19);
    drive(1'b1, 1'b0, 2'b00, ~7'h12);
    samp(1'b0, 0, 7'h19);
    repeat (3) idle(1'b0);
    check("t4_digit0", digit_values[0], 7'h19);
    check("t4_no_frame", fd_seen - fd_base, 0);
    samp(1'b0, 1, 7'h19);
    repeat (3) idle(1'b0);
    check("t4_frame", fd_seen - fd_base, 1);
    check("t4_sel_err", se_seen - se_base, 1);

    // Every glyph, then blank and an illegal pattern
    for (int g = 0; g < 16; g++) begin
      samp(1'b0, 1, glyph[g]);
      samp(1'b0, 1, glyph[g]);
      idle(1'b0);
      check("t5_hex_value", hex_value[1], g);
      check("t5_hex_valid", hex_valid[1], 1'b1);
    end
    repeat (2) samp(1'b0, 1, 7'h7F);
    idle(1'b0);
    check("t5_blank_valid", hex_valid[1], 1'b0);
    check("t5_blank_value", hex_value[1], 4'h0);
    repeat (2) samp(1'b0, 1, 7'h55);
    idle(1'b0);
    check("t5_bad_valid", hex_valid[1], 1'b0);
    check("t5_bad_value", hex_value[1], 4'h0);
    check("t5_bad_digit", digit_values[1], 7'h55);

    // Reset in the middle of a run discards the partial count
    repeat (2) samp(1'b0, 0, 7'h06);
    idle(1'b0);
    samp(1'b0, 0, 7'h0E);
    do_reset(1'b0);
    check("t6_reset_digits", digit_values, 14'h3FFF);
    check("t6_reset_valid", hex_valid, 2'b00);
    samp(1'b0, 0, 7'h0E);
    idle(1'b0);
    idle(1'b0);
    check("t6_no_resume", digit_values[0], 7'h7F);

    repeat (3) idle(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
